// File: rtl/servo_gauge_sequencer.sv
// ---------------------------------------------------------------------------
// servo_gauge_sequencer
//
// Produces the speed value for the servo PWM block that drives the analog
// speedometer needle. After reset the needle sweeps 0 -> SWEEP_MAX, dwells
// for DWELL_FRAMES frames and returns to 0. It then tracks the latched target,
// moving at most STEP per servo frame and ignoring differences of DEADBAND or
// less so the needle does not jitter.
//
// Optional feature: define GAUGE_PEAK_HOLD_EN to enable the peak-hold
// register. Without it, peak_speed is tied to 0 and peak_clr is ignored.
//
// Ports:
//   clk          in   system clock (50 MHz)
//   rst_n        in   asynchronous active-low reset
//   target_speed in   [7:0] requested speed
//   target_valid in   latch target_speed (clamped to SWEEP_MAX)
//   sweep_req    in   request a needle sweep (honoured only in TRACK)
//   peak_clr     in   load peak_speed with the current gauge_speed
//   gauge_speed  out  [7:0] rate-limited speed to the servo PWM block
//   frame_tick   out  one-cycle pulse at each frame boundary
//   busy         out  high whenever the sequencer is not tracking
//   settled      out  tracking and |target - gauge| <= DEADBAND
//   peak_speed   out  [7:0] highest gauge value seen while tracking
// ---------------------------------------------------------------------------
module servo_gauge_sequencer #(
  parameter int unsigned FRAME_CYCLES = 1_000_000,
  parameter int unsigned STEP         = 4,
  parameter int unsigned SWEEP_MAX    = 192,
  parameter int unsigned DWELL_FRAMES = 10,
  parameter int unsigned DEADBAND     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] target_speed,
  input  logic       target_valid,
  input  logic       sweep_req,
  input  logic       peak_clr,
  output logic [7:0] gauge_speed,
  output logic       frame_tick,
  output logic       busy,
  output logic       settled,
  output logic [7:0] peak_speed
);

  localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int DW_W  = (DWELL_FRAMES > 0) ? $clog2(DWELL_FRAMES + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL_FRAMES);
  localparam logic [8:0]       STEP9    = 9'(STEP);
  localparam logic [8:0]       MAX9     = 9'(SWEEP_MAX);
  localparam logic [8:0]       DB9      = 9'(DEADBAND);
  localparam logic [7:0]       MAX8     = 8'(SWEEP_MAX);

  typedef enum logic [1:0] {
    SWEEP_UP,
    DWELL,
    SWEEP_DOWN,
    TRACK
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [7:0]       gauge_q, gauge_d;
  logic [7:0]       target_q, target_d;

  // 9-bit working values so add/subtract never wrap.
  logic [8:0] sum;
  logic [8:0] diff;
  logic [8:0] mag;
  logic [8:0] step;

  // Frame timer: tick is registered, so it is high in the cycle after the
  // counter sits at its last value.
  always_comb begin
    cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    tick_d = (cnt_q == CNT_LAST);
  end

  // Signed distance from gauge to target and its magnitude.
  always_comb begin
    diff = {1'b0, target_q} - {1'b0, gauge_q};
    mag  = diff[8] ? (9'd0 - diff) : diff;
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d  = state_q;
    gauge_d  = gauge_q;
    dwell_d  = dwell_q;
    sum      = {1'b0, gauge_q} + STEP9;
    step     = (mag > STEP9) ? STEP9 : mag;
    target_d = target_q;

    // Targets are captured in every state; only TRACK acts on them.
    if (target_valid) begin
      target_d = (target_speed > MAX8) ? MAX8 : target_speed;
    end

    unique case (state_q)
      SWEEP_UP: begin
        if (tick_q) begin
          if (sum >= MAX9) begin
            gauge_d = MAX8;
            dwell_d = '0;
            state_d = DWELL;
          end else begin
            gauge_d = 8'(sum);
          end
        end
      end

      DWELL: begin
        if (tick_q) begin
          dwell_d = dwell_q + 1'b1;
          if (DW_W'(dwell_q + 1'b1) == DW_LAST) begin
            state_d = SWEEP_DOWN;
          end
        end
      end

      SWEEP_DOWN: begin
        if (tick_q) begin
          if ({1'b0, gauge_q} <= STEP9) begin
            gauge_d = '0;
            state_d = TRACK;
          end else begin
            gauge_d = 8'({1'b0, gauge_q} - STEP9);
          end
        end
      end

      TRACK: begin
        // A sweep request beats a coincident frame update.
        if (sweep_req) begin
          state_d = SWEEP_UP;
        end else if (tick_q && (mag > DB9)) begin
          // step <= |diff|, and the target is clamped, so the result stays
          // within 0..SWEEP_MAX.
          if (diff[8]) begin
            gauge_d = 8'({1'b0, gauge_q} - step);
          end else begin
            gauge_d = 8'({1'b0, gauge_q} + step);
          end
        end
      end

      default: state_d = SWEEP_UP;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SWEEP_UP;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      dwell_q  <= '0;
      gauge_q  <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      dwell_q  <= dwell_d;
      gauge_q  <= gauge_d;
      target_q <= target_d;
    end
  end

  assign gauge_speed = gauge_q;
  assign frame_tick  = tick_q;
  assign busy        = (state_q != TRACK);
  assign settled     = (state_q == TRACK) && (mag <= DB9);

`ifdef GAUGE_PEAK_HOLD_EN
  logic [7:0] peak_q, peak_d;

  // Clear loads the present needle position rather than zero, so the peak
  // restarts from where the needle actually is.
  always_comb begin
    peak_d = peak_q;
    if (peak_clr) begin
      peak_d = gauge_q;
    end else if ((state_q == TRACK) && tick_q && (gauge_d > peak_q)) begin
      peak_d = gauge_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_speed = peak_q;
`else
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr;
  assign peak_speed      = '0;
`endif

endmodule

// File: tb/tb_servo_gauge_sequencer.sv
// ---------------------------------------------------------------------------
// tb_servo_gauge_sequencer
//
// Directed bench for servo_gauge_sequencer with FRAME_CYCLES=100, STEP=4,
// SWEEP_MAX=192, DWELL_FRAMES=2, DEADBAND=1. Expected values are written out
// from the behaviour of the needle sequencer. Peak-hold expectations follow
// GAUGE_PEAK_HOLD_EN (0 when the feature is compiled out).
// ---------------------------------------------------------------------------
module tb_servo_gauge_sequencer;

`ifdef GAUGE_PEAK_HOLD_EN
  localparam bit PEAK_EN = 1'b1;
`else
  localparam bit PEAK_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] target_speed;
  logic       target_valid;
  logic       sweep_req;
  logic       peak_clr;
  logic [7:0] gauge_speed;
  logic       frame_tick;
  logic       busy;
  logic       settled;
  logic [7:0] peak_speed;

  int checks;
  int failures;
  int last_period;

  servo_gauge_sequencer #(
    .FRAME_CYCLES(100),
    .STEP        (4),
    .SWEEP_MAX   (192),
    .DWELL_FRAMES(2),
    .DEADBAND    (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .target_speed(target_speed),
    .target_valid(target_valid),
    .sweep_req   (sweep_req),
    .peak_clr    (peak_clr),
    .gauge_speed (gauge_speed),
    .frame_tick  (frame_tick),
    .busy        (busy),
    .settled     (settled),
    .peak_speed  (peak_speed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Poll negedges until frame_tick is seen high, bounded by 250 cycles.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((frame_tick !== 1'b1) && (n < 250));
    if (frame_tick !== 1'b1) check("tick_timeout", 0, 1);
  endtask

  // Wait for a tick and step past the edge that applies its update.
  task automatic next_tick();
    int n;
    wait_tick(n);
    @(negedge clk);
    last_period = n + 1;
  endtask

  task automatic set_target(input int v);
    target_speed = 8'(v);
    target_valid = 1'b1;
    @(negedge clk);
    target_valid = 1'b0;
  endtask

  initial begin
    int exp_g;
    int n;
    checks       = 0;
    failures     = 0;
    last_period  = 0;
    rst_n        = 1'b0;
    target_speed = '0;
    target_valid = 1'b0;
    sweep_req    = 1'b0;
    peak_clr     = 1'b0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_gauge", gauge_speed, 0);
    check("rst_tick", frame_tick, 0);
    check("rst_busy", busy, 1);
    check("rst_settled", settled, 0);
    check("rst_peak", peak_speed, 0);
    rst_n = 1'b1;

    // ---- power-on sweep: up to 192 at tick 48, dwell 49-50, down to 0 at 98 ----
    for (int i = 1; i <= 98; i++) begin
      next_tick();
      if (i <= 48)      exp_g = 4 * i;
      else if (i <= 50) exp_g = 192;
      else              exp_g = 192 - 4 * (i - 50);
      check("sweep_gauge", gauge_speed, exp_g);
      if (i == 2 || i == 60) check("tick_period", last_period, 100);
      if (i == 97) check("sweep_busy", busy, 1);
    end
    check("track_busy", busy, 0);
    check("track_settled0", settled, 1);

    // ---- TRACK target 50 from 0 ----
    set_target(50);
    check("t50_unsettled", settled, 0);
    for (int k = 1; k <= 13; k++) begin
      next_tick();
      check("t50_ramp", gauge_speed, (k <= 12) ? 4 * k : 50);
    end
    check("t50_settled", settled, 1);
    next_tick();
    check("t50_hold", gauge_speed, 50);

    // ---- deadband: 51 and 49 cause no movement; 53 reached in one tick ----
    set_target(51);
    check("db51_settled", settled, 1);
    next_tick();
    check("db51_gauge", gauge_speed, 50);
    set_target(49);
    next_tick();
    check("db49_gauge", gauge_speed, 50);
    check("db49_settled", settled, 1);
    set_target(53);
    check("t53_unsettled", settled, 0);
    next_tick();
    check("t53_gauge", gauge_speed, 53);

    // ---- target 0 from 53: stops at 1 inside the deadband ----
    set_target(0);
    for (int k = 1; k <= 14; k++) begin
      next_tick();
      check("t0_ramp", gauge_speed, (k <= 13) ? 53 - 4 * k : 1);
    end
    check("t0_db_settled", settled, 1);
    set_target(4);
    next_tick();
    check("t4_gauge", gauge_speed, 4);
    set_target(0);
    next_tick();
    check("t0_gauge", gauge_speed, 0);

    // ---- target 255 clamps to 192 ----
    set_target(255);
    for (int k = 1; k <= 49; k++) begin
      next_tick();
      check("t255_ramp", gauge_speed, (k <= 48) ? 4 * k : 192);
    end
    check("t255_settled", settled, 1);
    set_target(0);
    for (int k = 1; k <= 48; k++) begin
      next_tick();
      check("t255_down", gauge_speed, 192 - 4 * k);
    end

    // ---- sweep_req coinciding with frame_tick at gauge 100 ----
    set_target(100);
    for (int k = 1; k <= 25; k++) begin
      next_tick();
      check("t100_ramp", gauge_speed, 4 * k);
    end
    wait_tick(n);
    sweep_req = 1'b1;
    @(negedge clk);
    sweep_req = 1'b0;
    check("sreq_gauge", gauge_speed, 100);
    check("sreq_busy", busy, 1);
    set_target(30);
    for (int k = 1; k <= 23; k++) begin
      next_tick();
      check("sreq_up", gauge_speed, 100 + 4 * k);
    end
    next_tick();
    check("sreq_dwell1", gauge_speed, 192);
    // Ignored outside TRACK.
    sweep_req = 1'b1;
    @(negedge clk);
    sweep_req = 1'b0;
    next_tick();
    check("sreq_dwell2", gauge_speed, 192);
    for (int k = 1; k <= 48; k++) begin
      next_tick();
      check("sreq_down", gauge_speed, 192 - 4 * k);
      if (k == 47) check("sreq_busy_down", busy, 1);
    end
    check("sreq_track_busy", busy, 0);
    check("sreq_track_unsettled", settled, 0);
    for (int k = 1; k <= 8; k++) begin
      next_tick();
      check("t30_ramp", gauge_speed, (k <= 7) ? 4 * k : 30);
    end

    // ---- peak hold: track to 120 then 60 ----
    set_target(120);
    for (int k = 1; k <= 23; k++) begin
      next_tick();
      check("t120_ramp", gauge_speed, (k <= 22) ? 30 + 4 * k : 120);
    end
    check("peak_120", peak_speed, PEAK_EN ? 120 : 0);
    set_target(60);
    for (int k = 1; k <= 15; k++) begin
      next_tick();
      check("t60_ramp", gauge_speed, 120 - 4 * k);
    end
    check("peak_hold", peak_speed, PEAK_EN ? 120 : 0);
    peak_clr = 1'b1;
    @(negedge clk);
    peak_clr = 1'b0;
    check("peak_clr", peak_speed, PEAK_EN ? 60 : 0);

    // ---- reset asserted mid SWEEP_DOWN ----
    sweep_req = 1'b1;
    @(negedge clk);
    sweep_req = 1'b0;
    check("sweep2_busy", busy, 1);
    for (int k = 1; k <= 33; k++) begin
      next_tick();
      check("sweep2_up", gauge_speed, 60 + 4 * k);
    end
    check("sweep2_peak", peak_speed, PEAK_EN ? 60 : 0);
    repeat (2) next_tick();
    for (int k = 1; k <= 3; k++) begin
      next_tick();
      check("sweep2_down", gauge_speed, 192 - 4 * k);
    end
    wait_tick(n);
    check("pre_rst_tick", frame_tick, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_gauge", gauge_speed, 0);
    check("arst_tick", frame_tick, 0);
    check("arst_peak", peak_speed, 0);
    check("arst_busy", busy, 1);
    check("arst_settled", settled, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      next_tick();
      check("restart_up", gauge_speed, 4 * k);
      check("restart_busy", busy, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/servo_gauge_sequencer.md
Name: servo_gauge_sequencer

Overview:
- Sequences the speed value fed to the servo PWM generator that drives the analog speedometer needle.
- At power-on it runs a needle sweep: 0 to full scale, dwell, back to 0.
- It then tracks the requested speed, rate-limited once per 20 ms servo frame, with a deadband so the needle does not jitter.
- Sits between the vehicle speed logic and the servo PWM block; its gauge_speed output drives that block's 8-bit speed input.

Parameters:
- FRAME_CYCLES, 1_000_000: clock cycles per servo frame (20 ms at 50 MHz).
- STEP, 4: maximum gauge_speed change per frame.
- SWEEP_MAX, 192: full-scale value. Targets above it are clamped, and sweeps peak at it.
- DWELL_FRAMES, 10: frames held at SWEEP_MAX during a sweep.
- DEADBAND, 1: a target/gauge difference at or below this causes no movement.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- target_speed  in  8  requested speed
- target_valid  in  1  latches target_speed on any cycle it is high
- sweep_req  in  1  request a needle sweep; honoured only in TRACK
- peak_clr  in  1  clear the peak-hold register (optional feature)
- gauge_speed  out  8  rate-limited speed to the servo PWM block
- frame_tick  out  1  one-cycle pulse at each frame boundary
- busy  out  1  high whenever state is not TRACK
- settled  out  1  TRACK and |target - gauge| <= DEADBAND
- peak_speed  out  8  peak gauge value (optional feature)

Behaviour:
- Reset (rst_n low, asynchronous): frame counter 0, gauge_speed 0, latched target 0, peak_speed 0, frame_tick 0, dwell count 0, state SWEEP_UP.
  - busy = 1 and settled = 0, both combinational from state.
  - Asserting reset mid-sweep or mid-track restarts the power-on sweep.
- Frame counter:
  - Counts 0 to FRAME_CYCLES-1, then wraps to 0.
  - frame_tick is registered and high for the single cycle after the counter equals FRAME_CYCLES-1.
  - All gauge updates occur only in frame_tick cycles.
- Target latch: on target_valid, latched target = min(target_speed, SWEEP_MAX). Latching happens in every state; the value is applied only in TRACK.
- SWEEP_UP: each tick, gauge = min(gauge + STEP, SWEEP_MAX). On the tick where gauge becomes SWEEP_MAX, go to DWELL and clear the dwell count.
- DWELL: each tick increments the dwell count. On the DWELL_FRAMES-th tick, go to SWEEP_DOWN; gauge is unchanged.
- SWEEP_DOWN: each tick, gauge = gauge - STEP, saturating at 0. On the tick where gauge reaches 0, go to TRACK.
- TRACK: each tick, d = target - gauge (signed 9-bit).
  - If |d| <= DEADBAND: no change.
  - Otherwise gauge moves toward target by min(STEP, |d|).
  - gauge never leaves 0..SWEEP_MAX.
- sweep_req:
  - In TRACK, sampled high moves the state to SWEEP_UP on the next clock; the sweep starts from the current gauge value.
  - If sweep_req and frame_tick coincide in TRACK, the sweep wins and no tracking update happens that tick.
  - Ignored in all other states.
- Arithmetic uses 9-bit intermediates, so there is no wrap-around on add or subtract.

Optional Feature:
- Macro: GAUGE_PEAK_HOLD_EN.
- Defined:
  - On each TRACK tick, peak_speed = max(peak_speed, new gauge).
  - peak_clr high sets peak_speed to the current gauge_speed next clock; this has priority over the update.
  - peak_speed does not update during sweeps.
- Undefined: peak_speed is tied to 0 and peak_clr is ignored. Ports remain for interface stability.

Test Plan (FRAME_CYCLES=100, STEP=4, SWEEP_MAX=192, DWELL_FRAMES=2, DEADBAND=1):
- Reset release: gauge steps +4 per tick to 192 at tick 48, holds for ticks 49-50, then -4 per tick to 0 at tick 98. busy falls the cycle after tick 98; frame_tick period is 100 cycles.
- TRACK, target 50 from 0: gauge 4, 8, …, 48 over 12 ticks, then 50 on tick 13. settled=1; subsequent ticks leave 50.
- TRACK at 50, target 51 then 49: no gauge change, settled stays 1. Target 53: gauge becomes 53 in one tick.
- Target 255 from 0: latched 192; gauge reaches 192 after 48 ticks and never exceeds it. Target 0: ramps down by 4 to 0.
- TRACK at gauge 100, sweep_req in the same cycle as frame_tick: gauge stays 100 that tick, busy=1, then 104, 108, … to 192, dwell, down to 0. target_valid=30 during the sweep is applied only after TRACK resumes.
- GAUGE_PEAK_HOLD_EN defined: track to 120 then 60, and peak_speed=120; pulse peak_clr, and peak_speed=60. Assert rst_n low mid-SWEEP_DOWN: gauge_speed, peak_speed and frame_tick are 0 immediately, and the sweep restarts on release.
